// File: rtl/pkt_hdr_parser_pkg.sv
// Shared types and constants for the receive-side packet header parser.
package pkt_hdr_parser_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;
    localparam int HDR_BYTES  = 11;
    localparam int IDX_W      = 7;

    // Packet type codes carried in byte0[7:5]
    localparam logic [2:0] PKT_HB    = 3'b000;
    localparam logic [2:0] PKT_CHE   = 3'b001;
    localparam logic [2:0] PKT_TS    = 3'b100;
    localparam logic [2:0] PKT_DATA  = 3'b101;
    localparam logic [2:0] PKT_SOS   = 3'b110;
    localparam logic [2:0] PKT_NONE  = 3'b111;

    // Byte offsets of each header field (high byte first)
    localparam logic [IDX_W-1:0] OFF_TYPE = 7'd0;
    localparam logic [IDX_W-1:0] OFF_SRC  = 7'd1;
    localparam logic [IDX_W-1:0] OFF_DST  = 7'd3;
    localparam logic [IDX_W-1:0] OFF_HOPS = 7'd5;
    localparam logic [IDX_W-1:0] OFF_TS   = 7'd7;
    localparam logic [IDX_W-1:0] OFF_THR  = 7'd9;
    localparam logic [IDX_W-1:0] HDR_LAST = 7'(HDR_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 7'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]            ptype;
        logic [WORD_WIDTH-1:0] src;
        logic [WORD_WIDTH-1:0] dst;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] ts;
        logic [WORD_WIDTH-1:0] thr;
    } hdr_t;

    localparam hdr_t HDR_RESET = '{ptype: PKT_NONE, default: '0};

endpackage

// File: rtl/pkt_hdr_parser.sv
// Byte-serial header parser: captures header bytes into a shadow bank and
// commits them to the outputs with a one-cycle en_MNI strobe per good packet.
module pkt_hdr_parser
    import pkt_hdr_parser_pkg::*;
#(
    parameter int BYTE_W        = MEM_WIDTH,
    parameter int WORD_W        = WORD_WIDTH,
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              en_MNI,
    output logic [2:0]        fPktType,
    output logic [WORD_W-1:0] sourceID,
    output logic [WORD_W-1:0] destinationID,
    output logic [WORD_W-1:0] hops,
    output logic [WORD_W-1:0] timeslot,
    output logic [WORD_W-1:0] e_threshold,
    output logic              err_short,
    output logic              err_long,
    output logic [15:0]       pkt_count
);

    // Index of the byte that overflows a legal packet (byte number MAX+1)
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_PKT_BYTES);

    state_t           state, next_state;
    logic [IDX_W-1:0] byte_idx;
    hdr_t             sh_q, sh_d, out_q;
    logic             accept, commit, short_d, long_d;

    assign accept   = in_valid & in_ready;
    // EMIT is the only state that stalls the stream
    assign in_ready = ~rst & (state != ST_EMIT);
    assign en_MNI   = (state == ST_EMIT);

    assign fPktType      = out_q.ptype;
    assign sourceID      = out_q.src;
    assign destinationID = out_q.dst;
    assign hops          = out_q.hops;
    assign timeslot      = out_q.ts;
    assign e_threshold   = out_q.thr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state, commit and error decode
    always_comb begin
        next_state = state;
        commit     = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                if (in_last) short_d = 1'b1;
                else         next_state = ST_HDR;
            end
            ST_HDR: if (accept) begin
                if (in_last) begin
                    if (byte_idx == HDR_LAST) begin
                        next_state = ST_EMIT;
                        commit     = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                        short_d    = 1'b1;
                    end
                end else if (byte_idx == HDR_LAST) begin
                    next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (accept) begin
                if (byte_idx == MAX_IDX) begin
                    long_d     = 1'b1;
                    next_state = in_last ? ST_IDLE : ST_DROP;
                end else if (in_last) begin
                    next_state = ST_EMIT;
                    commit     = 1'b1;
                end
            end
            ST_DROP: if (accept && in_last) next_state = ST_IDLE;
            ST_EMIT: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Shadow bank with the byte being accepted this cycle merged in, so the
    // final header byte is visible to a commit on the same edge
    always_comb begin
        sh_d = sh_q;
        if (accept && (state == ST_IDLE || state == ST_HDR)) begin
            case (byte_idx)
                OFF_TYPE:            sh_d.ptype           = in_data[7:5];
                OFF_SRC:             sh_d.src[15:8]       = in_data;
                OFF_SRC + IDX_ONE:   sh_d.src[7:0]        = in_data;
                OFF_DST:             sh_d.dst[15:8]       = in_data;
                OFF_DST + IDX_ONE:   sh_d.dst[7:0]        = in_data;
                OFF_HOPS:            sh_d.hops[15:8]      = in_data;
                OFF_HOPS + IDX_ONE:  sh_d.hops[7:0]       = in_data;
                OFF_TS:              sh_d.ts[15:8]        = in_data;
                OFF_TS + IDX_ONE:    sh_d.ts[7:0]         = in_data;
                OFF_THR:             sh_d.thr[15:8]       = in_data;
                OFF_THR + IDX_ONE:   sh_d.thr[7:0]        = in_data;
                default:             sh_d = sh_q;
            endcase
        end
    end

    // Byte counter, shadow/output banks, error pulses and good-packet count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx  <= '0;
            sh_q      <= HDR_RESET;
            out_q     <= HDR_RESET;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            pkt_count <= '0;
        end else begin
            sh_q      <= sh_d;
            err_short <= short_d;
            err_long  <= long_d;
            if (next_state == ST_IDLE)
                byte_idx <= '0;
            else if (accept && state != ST_DROP)
                byte_idx <= byte_idx + IDX_ONE;
            if (commit) begin
                out_q     <= sh_d;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_hdr_parser.sv
// Directed self-checking bench for pkt_hdr_parser.
module tb_pkt_hdr_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready, en_MNI, err_short, err_long;
    logic [2:0]  fPktType;
    logic [15:0] sourceID, destinationID, hops, timeslot, e_threshold, pkt_count;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0, es_cnt = 0, el_cnt = 0;
    logic [7:0] pkt[$];

    pkt_hdr_parser #(.BYTE_W(8), .WORD_W(16), .MAX_PKT_BYTES(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .en_MNI(en_MNI),
        .fPktType(fPktType), .sourceID(sourceID), .destinationID(destinationID),
        .hops(hops), .timeslot(timeslot), .e_threshold(e_threshold),
        .err_short(err_short), .err_long(err_long), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (en_MNI === 1'b1)    en_cnt++;
        if (err_short === 1'b1) es_cnt++;
        if (err_long === 1'b1)  el_cnt++;
    end

    // Present one byte and hold until transferred; returns stall cycles
    task automatic send_byte(input logic [7:0] d, input logic last, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        stalls   = 0;
        while (in_ready !== 1'b1 && stalls < 20) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 20) begin
            n_vec++; n_err++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    // Stream the queue 'pkt', last flag on the final byte; returns stalls on byte 0
    task automatic send_pkt(input bit drop_valid, output int first_stalls);
        int s;
        first_stalls = 0;
        foreach (pkt[i]) begin
            send_byte(pkt[i], (i == pkt.size() - 1), s);
            if (i == 0) first_stalls = s;
        end
        if (drop_valid) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic chk_hdr(input string nm, input logic [2:0] t, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] h,
                           input logic [15:0] ts, input logic [15:0] th);
        n_vec++;
        if ({fPktType, sourceID, destinationID, hops, timeslot, e_threshold} !==
            {t, s, d, h, ts, th}) begin
            n_err++;
            $display("FAIL %s fields: got %h %h %h %h %h %h required %h %h %h %h %h %h", nm,
                     fPktType, sourceID, destinationID, hops, timeslot, e_threshold,
                     t, s, d, h, ts, th);
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", in_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_hdr("reset", 3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        n_vec++;
        if ({en_MNI, err_short, err_long, pkt_count} !== 19'h0) begin
            n_err++; $display("FAIL reset_flags: got %b %b %b %h required 0 0 0 0000", en_MNI, err_short, err_long, pkt_count);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_hb();
        int s;
        pkt = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'hF4};
        send_pkt(1, s);
        n_vec++;
        if (en_MNI !== 1'b1 || pkt_count !== 16'd1) begin
            n_err++; $display("FAIL hb_strobe: en=%b cnt=%h required 1 0001", en_MNI, pkt_count);
        end
        chk_hdr("hb", 3'b000, 16'h0001, 16'hFFFF, 16'h0003, 16'h0000, 16'h01F4);
        @(posedge clk); #1;
        n_vec++;
        if (en_MNI !== 1'b0) begin n_err++; $display("FAIL hb_one_cycle: en=%b required 0", en_MNI); end
    endtask

    task automatic test_short();
        int s, e0, es0;
        e0 = en_cnt; es0 = es_cnt;
        pkt = '{8'h20, 8'h00, 8'h05, 8'h00, 8'h06, 8'h77};
        send_pkt(1, s);
        n_vec++;
        if (err_short !== 1'b1 || en_MNI !== 1'b0) begin
            n_err++; $display("FAIL short_pulse: err_short=%b en=%b required 1 0", err_short, en_MNI);
        end
        chk_hdr("short_hold", 3'b000, 16'h0001, 16'hFFFF, 16'h0003, 16'h0000, 16'h01F4);
        // single-byte packet
        pkt = '{8'hC0};
        send_pkt(1, s);
        n_vec++;
        if (err_short !== 1'b1) begin n_err++; $display("FAIL short_single: err_short=%b required 1", err_short); end
        @(posedge clk); #1;
        n_vec++;
        if (err_short !== 1'b0 || pkt_count !== 16'd1 || en_cnt != e0 || es_cnt != es0 + 2) begin
            n_err++; $display("FAIL short_after: err_short=%b cnt=%h en_pulses=%0d es_pulses=%0d required 0 0001 0 2",
                              err_short, pkt_count, en_cnt - e0, es_cnt - es0);
        end
    endtask

    task automatic test_timeslot();
        int s, e0;
        e0 = en_cnt;
        pkt = '{8'h80, 8'h00, 8'h02, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h05, 8'h00, 8'h10,
                8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_pkt(1, s);
        n_vec++;
        if (en_MNI !== 1'b1 || pkt_count !== 16'd2) begin
            n_err++; $display("FAIL ts_strobe: en=%b cnt=%h required 1 0002", en_MNI, pkt_count);
        end
        chk_hdr("ts", 3'b100, 16'h0002, 16'h000C, 16'h0003, 16'h0005, 16'h0010);
        @(posedge clk); #1;
        n_vec++;
        if (en_cnt != e0 + 1) begin n_err++; $display("FAIL ts_single_strobe: pulses=%0d required 1", en_cnt - e0); end
    endtask

    task automatic test_long();
        int s, e0, el0, bad_ready;
        e0 = en_cnt; el0 = el_cnt; bad_ready = 0;
        // exactly 64 bytes is still legal
        pkt.delete();
        for (int i = 0; i < 64; i++) pkt.push_back((i == 0) ? 8'hA0 : 8'(i));
        send_pkt(1, s);
        n_vec++;
        if (en_MNI !== 1'b1 || err_long !== 1'b0 || pkt_count !== 16'd3) begin
            n_err++; $display("FAIL long_boundary64: en=%b err_long=%b cnt=%h required 1 0 0003", en_MNI, err_long, pkt_count);
        end
        chk_hdr("long_boundary64", 3'b101, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A);
        @(posedge clk); #1;
        e0 = en_cnt;
        // 70-byte packet
        for (int i = 0; i < 70; i++) begin
            send_byte((i == 0) ? 8'h20 : 8'(8'h80 + i), (i == 69), s);
            if (i == 64) begin
                n_vec++;
                if (err_long !== 1'b1) begin n_err++; $display("FAIL long_pulse: err_long=%b required 1 after byte 65", err_long); end
            end
            if (i >= 64 && i < 69 && (in_ready !== 1'b1 || s != 0)) bad_ready++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_vec++;
        if (bad_ready != 0) begin n_err++; $display("FAIL long_drop_ready: bad cycles=%0d required 0", bad_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (en_cnt != e0 || el_cnt != el0 + 1 || pkt_count !== 16'd3) begin
            n_err++; $display("FAIL long_no_emit: en_pulses=%0d el_pulses=%0d cnt=%h required 0 1 0003",
                              en_cnt - e0, el_cnt - el0, pkt_count);
        end
        chk_hdr("long_hold", 3'b101, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A);
        pkt = '{8'hC5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hED};
        send_pkt(1, s);
        n_vec++;
        if (en_MNI !== 1'b1 || pkt_count !== 16'd4) begin
            n_err++; $display("FAIL long_recover: en=%b cnt=%h required 1 0004", en_MNI, pkt_count);
        end
        chk_hdr("long_recover", 3'b110, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0FED);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int s, e0;
        e0 = en_cnt;
        pkt = '{8'h20, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55, 8'h55, 8'h99, 8'h98};
        send_pkt(0, s);
        n_vec++;
        if (en_MNI !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_emit_a: en=%b ready=%b required 1 0", en_MNI, in_ready);
        end
        chk_hdr("b2b_a", 3'b001, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        pkt = '{8'hA3, 8'h66, 8'h66, 8'h77, 8'h77, 8'h88, 8'h88, 8'h99, 8'h99, 8'hAA, 8'hAA};
        send_pkt(1, s);
        n_vec++;
        if (s != 1) begin n_err++; $display("FAIL b2b_stall: stall cycles=%0d required 1", s); end
        n_vec++;
        if (en_MNI !== 1'b1 || pkt_count !== 16'd6) begin
            n_err++; $display("FAIL b2b_emit_b: en=%b cnt=%h required 1 0006", en_MNI, pkt_count);
        end
        chk_hdr("b2b_b", 3'b101, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA);
        @(posedge clk); #1;
        n_vec++;
        if (en_cnt != e0 + 2) begin n_err++; $display("FAIL b2b_pulses: pulses=%0d required 2", en_cnt - e0); end
    endtask

    task automatic test_mid_reset();
        int s;
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0, s);
        rst = 1'b1;
        #2;
        n_vec++;
        if (in_ready !== 1'b0 || en_MNI !== 1'b0 || pkt_count !== 16'd0) begin
            n_err++; $display("FAIL rst_async: ready=%b en=%b cnt=%h required 0 0 0000", in_ready, en_MNI, pkt_count);
        end
        chk_hdr("rst_async", 3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        pkt = '{8'h9F, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13};
        send_pkt(1, s);
        n_vec++;
        if (en_MNI !== 1'b1 || pkt_count !== 16'd1) begin
            n_err++; $display("FAIL rst_fresh: en=%b cnt=%h required 1 0001", en_MNI, pkt_count);
        end
        chk_hdr("rst_fresh", 3'b100, 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_hb();
        test_short();
        test_timeslot();
        test_long();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
